operand_stack: RTL and testbench



---
 rtl/operand_stack.sv | 153 +++++++++++++++
 tb/tb_operand_stack.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_stack.sv
// operand_stack: 32-bit LIFO operand store serving the control block's
// single-request push/pop handshake. Each accepted request runs IDLE -> OP -> ACK,
// ending with a one-cycle done pulse. Storage is written synchronously and read into
// a register, so it maps onto block RAM.
module operand_stack #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          trigger,
   input  logic          push,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata,
   output logic          done,
   output logic [AW:0]   count,
   output logic          overflow,
   output logic          underflow
);

   typedef enum logic [1:0] {
      StIdle,
      StOp,
      StAck
   } state_e;

   localparam logic [AW:0] SpFull = (AW + 1)'(DEPTH);
   localparam logic [AW:0] SpOne  = (AW + 1)'(1);

   logic [31:0] mem [DEPTH];

   state_e      state_q, state_d;
   logic        push_q, push_d;
   logic [31:0] wdata_q, wdata_d;
   logic [AW:0] sp_q, sp_d;
   logic        done_q, done_d;
   logic        ovf_q, ovf_d;
   logic        unf_q, unf_d;
   logic [31:0] rdata_q;

   logic          full;
   logic          empty;
   logic [AW:0]   sp_dec;
   logic [AW-1:0] waddr;
   logic [AW-1:0] raddr;
   logic          mem_we;
   logic          mem_re;
   logic          rd_clr;

   assign full   = (sp_q == SpFull);
   assign empty  = (sp_q == '0);
   assign sp_dec = sp_q - SpOne;
   assign waddr  = sp_q[AW-1:0];
   assign raddr  = sp_dec[AW-1:0];

   // Next-state logic: request capture in IDLE, the stack access in OP, done in ACK.
   always_comb begin
      state_d = state_q;
      push_d  = push_q;
      wdata_d = wdata_q;
      sp_d    = sp_q;
      done_d  = 1'b0;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      mem_we  = 1'b0;
      mem_re  = 1'b0;
      rd_clr  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (trigger) begin
               push_d  = push;
               wdata_d = wdata;
               state_d = StOp;
            end
         end
         StOp: begin
            if (push_q) begin
               if (full) begin
                  ovf_d = 1'b1;
               end else begin
                  mem_we = 1'b1;
                  sp_d   = sp_q + SpOne;
               end
            end else begin
               if (empty) begin
                  // Popping an empty stack still completes, returning zero.
                  rd_clr = 1'b1;
                  unf_d  = 1'b1;
               end else begin
                  mem_re = 1'b1;
                  sp_d   = sp_dec;
               end
            end
            done_d  = 1'b1;
            state_d = StAck;
         end
         StAck: begin
            // Any trigger seen here or in OP is dropped; no queueing.
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Control and status registers; reset aborts any request in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         push_q  <= 1'b0;
         wdata_q <= '0;
         sp_q    <= '0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         push_q  <= push_d;
         wdata_q <= wdata_d;
         sp_q    <= sp_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Storage write port; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         mem[waddr] <= wdata_q;
      end
   end

   // Registered read port; holds the last popped value until the next pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (mem_re) begin
         rdata_q <= mem[raddr];
      end else if (rd_clr) begin
         rdata_q <= '0;
      end
   end

   assign rdata     = rdata_q;
   assign done      = done_q;
   assign count     = sp_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;

endmodule

// File: tb/tb_operand_stack.sv
// Bench for operand_stack: a queue-based stack model checked every cycle, directed
// scenarios with literal expectations, then randomized request traffic.
module tb_operand_stack;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          trigger = 1'b0;
   logic          push = 1'b0;
   logic [31:0]   wdata = '0;
   logic [31:0]   rdata;
   logic          done;
   logic [AW:0]   count;
   logic          overflow;
   logic          underflow;

   operand_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .trigger   (trigger),
      .push      (push),
      .wdata     (wdata),
      .rdata     (rdata),
      .done      (done),
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   bit armed = 1'b0;

   // Behavioural model: a request is taken when idle, its effect lands one edge
   // later together with done, and the block is free again one edge after that.
   logic [31:0] m_q[$];
   int          m_busy = 0;
   logic        m_push;
   logic [31:0] m_data;
   logic        m_done = 1'b0;
   logic [31:0] m_rdata = '0;
   logic        m_ovf = 1'b0;
   logic        m_unf = 1'b0;

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            armed   = 1'b1;
            m_q.delete();
            m_busy  = 0;
            m_done  = 1'b0;
            m_rdata = '0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
         end else if (m_busy == 0) begin
            m_done = 1'b0;
            if (trigger) begin
               m_push = push;
               m_data = wdata;
               m_busy = 2;
            end
         end else if (m_busy == 2) begin
            if (m_push) begin
               if (m_q.size() == DEPTH) m_ovf = 1'b1;
               else m_q.push_back(m_data);
            end else begin
               if (m_q.size() == 0) begin
                  m_rdata = '0;
                  m_unf   = 1'b1;
               end else begin
                  m_rdata = m_q.pop_back();
               end
            end
            m_done = 1'b1;
            m_busy = 1;
         end else begin
            m_done = 1'b0;
            m_busy = 0;
         end
      end
   end

   // Every-cycle comparison against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (armed) begin
            n_vec++;
            if (done !== m_done || count !== 3'(m_q.size()) || rdata !== m_rdata ||
                overflow !== m_ovf || underflow !== m_unf) begin
               n_err++;
               $display("FAIL cycle%0d: got done=%b count=%0d rdata=%h ovf=%b unf=%b, expected done=%b count=%0d rdata=%h ovf=%b unf=%b",
                        cyc, done, count, rdata, overflow, underflow,
                        m_done, m_q.size(), m_rdata, m_ovf, m_unf);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      trigger = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst = 1'b0;
   endtask

   // Issue one request with trigger held for `hold` cycles; returns in the done cycle.
   task automatic req(input logic p, input logic [31:0] d, input int hold,
                      output int lat, output int start);
      int idx;
      @(posedge clk); #1;
      trigger = 1'b1;
      push    = p;
      wdata   = d;
      start   = cyc;
      idx     = 0;
      lat     = -1;
      forever begin
         @(negedge clk);
         if (done) begin
            lat = idx;
            break;
         end
         @(posedge clk); #1;
         idx++;
         if (idx >= hold) trigger = 1'b0;
         if (idx > 8) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: got no done after %0d cycles, required within 2", idx);
            trigger = 1'b0;
            break;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         trigger = 1'b0;
      end
   endtask

   int lat, s0, s1, pulses;
   logic [AW:0] c0;

   initial begin
      // Reset then push/pop/pop
      do_reset();
      @(negedge clk);
      chk("reset_count", 32'(count), 32'd0);
      chk("reset_rdata", rdata, 32'd0);
      chk("reset_flags", {30'd0, overflow, underflow}, 32'd0);
      req(1'b1, 32'h0000_0007, 1, lat, s0);
      chk("push_latency", 32'(lat), 32'd2);
      req(1'b1, 32'hFFFF_FFFE, 1, lat, s0);
      req(1'b0, 32'h0, 1, lat, s0);
      chk("pop1_rdata", rdata, 32'hFFFF_FFFE);
      chk("pop1_count", 32'(count), 32'd1);
      chk("pop_latency", 32'(lat), 32'd2);
      req(1'b0, 32'h0, 1, lat, s0);
      chk("pop2_rdata", rdata, 32'h0000_0007);
      chk("pop2_count", 32'(count), 32'd0);

      // Underflow
      req(1'b0, 32'h0, 1, lat, s0);
      chk("unf_rdata", rdata, 32'd0);
      chk("unf_flag", 32'(underflow), 32'd1);
      chk("unf_count", 32'(count), 32'd0);
      req(1'b1, 32'h0000_1234, 1, lat, s0);
      req(1'b0, 32'h0, 1, lat, s0);
      chk("unf_after_pop", rdata, 32'h0000_1234);
      chk("unf_sticky", 32'(underflow), 32'd1);

      // Overflow
      do_reset();
      for (int i = 1; i <= 4; i++) req(1'b1, 32'(i), 1, lat, s0);
      chk("ovf_full_count", 32'(count), 32'd4);
      req(1'b1, 32'd5, 1, lat, s0);
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_count", 32'(count), 32'd4);
      req(1'b0, 32'h0, 1, lat, s0);
      chk("ovf_pop", rdata, 32'd4);

      // Two-operand ALU sequence, back to back
      do_reset();
      req(1'b1, 32'd3, 1, lat, s0);
      req(1'b1, 32'd5, 1, lat, s1);
      chk("alu_spacing_push", 32'(s1 - s0), 32'd3);
      req(1'b0, 32'h0, 1, lat, s0);
      chk("alu_pop_a", rdata, 32'd5);
      req(1'b0, 32'h0, 1, lat, s1);
      chk("alu_pop_b", rdata, 32'd3);
      chk("alu_spacing_pop", 32'(s1 - s0), 32'd3);
      req(1'b1, 32'd8, 1, lat, s0);
      chk("alu_result_count", 32'(count), 32'd1);
      chk("alu_spacing_wb", 32'(s0 - s1), 32'd3);

      // Trigger held three cycles: one accepted request only
      c0 = count;
      req(1'b1, 32'hA5A5_A5A5, 3, lat, s0);
      chk("hold_count", 32'(count), 32'(c0) + 32'd1);
      pulses = 0;
      @(posedge clk); #1;
      trigger = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      chk("hold_extra_done", 32'(pulses), 32'd0);

      // Reset during the OP cycle of a push
      do_reset();
      req(1'b1, 32'h11, 1, lat, s0);
      req(1'b1, 32'h22, 1, lat, s0);
      @(posedge clk); #1;
      trigger = 1'b1;
      push    = 1'b1;
      wdata   = 32'h33;
      @(posedge clk); #1;
      trigger = 1'b0;
      rst     = 1'b1;
      @(posedge clk); #1;
      rst     = 1'b0;
      pulses  = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      chk("abort_no_done", 32'(pulses), 32'd0);
      chk("abort_count", 32'(count), 32'd0);
      chk("abort_flags", {30'd0, overflow, underflow}, 32'd0);
      req(1'b0, 32'h0, 1, lat, s0);
      chk("abort_then_pop_unf", 32'(underflow), 32'd1);

      // Randomized traffic
      do_reset();
      for (int it = 0; it < 300; it++) begin
         if ($urandom_range(0, 99) < 3) begin
            @(posedge clk); #1;
            trigger = 1'b1;
            push    = 1'($urandom_range(0, 1));
            wdata   = $urandom;
            @(posedge clk); #1;
            trigger = 1'b0;
            rst     = 1'b1;
            @(posedge clk); #1;
            rst     = 1'b0;
         end else begin
            req(1'($urandom_range(0, 99) < 55), $urandom, int'($urandom_range(1, 3)), lat, s0);
            idle(int'($urandom_range(0, 2)));
         end
      end
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
